fpu_mantissa_muldiv_iter: RTL and testbench

Parametrised iterative mantissa engine for the FP80 multiply/divide path. It computes the exact unsigned product, or a fixed-point quotient plus sticky bit, of two MANT_W-bit significands. The radix is selectable, and it adds valid/ready handshakes, back-pressure, abort and a tag pass-through. Exponent, sign, special-value and rounding logic stay in the enclosing FPU unit.

---
 rtl/fpu_muldiv_pkg.sv | 23 ++
 rtl/fpu_muldiv_step.sv | 52 +++++
 rtl/fpu_mantissa_muldiv_iter.sv | 156 +++++++++++++++
 tb/tb_fpu_mantissa_muldiv_iter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_muldiv_pkg.sv
// Shared encodings and sizing helpers for the iterative FP80 mantissa multiply/divide engine.
package fpu_muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int calc_q_w(input int mant_w, input int guard_bits);
        return mant_w + guard_bits;
    endfunction

    // Number of RUN cycles for an op: one cycle retires bpc bits.
    function automatic int calc_iter(input logic op, input int mant_w, input int guard_bits,
                                     input int bpc);
        return (op == OP_DIV) ? calc_q_w(mant_w, guard_bits) / bpc : mant_w / bpc;
    endfunction

endpackage

// File: rtl/fpu_muldiv_step.sv
// One radix-2^BITS_PER_CYCLE step: shift-add multiply or restoring divide, built from chained 1-bit steps.
module fpu_muldiv_step
    import fpu_muldiv_pkg::*;
#(
    parameter int MANT_W         = 64,
    parameter int Q_W            = 68,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              i_op,
    input  logic [MANT_W-1:0] i_a,
    input  logic [MANT_W-1:0] i_b,
    input  logic [2*MANT_W:0] i_acc,
    input  logic [Q_W-1:0]    i_sr,
    output logic [2*MANT_W:0] o_acc,
    output logic [Q_W-1:0]    o_sr
);

    logic [2*MANT_W:0] w_acc;
    logic [Q_W-1:0]    w_sr;
    logic [MANT_W:0]   w_sum;
    logic [MANT_W:0]   w_rem;

    // Multiply: acc = {hi, lo}, add a into hi when the multiplier LSB is set, then shift right.
    // Divide: acc[MANT_W:0] holds the partial remainder, quotient bits shift into sr from the LSB.
    always_comb begin
        w_acc = i_acc;
        w_sr  = i_sr;
        w_sum = '0;
        w_rem = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (i_op == OP_MUL) begin
                w_sum = w_acc[2*MANT_W:MANT_W] + (w_sr[0] ? {1'b0, i_a} : '0);
                w_acc = {1'b0, w_sum, w_acc[MANT_W-1:1]};
                w_sr  = w_sr >> 1;
            end else begin
                w_rem = w_acc[MANT_W:0];
                if (w_rem >= {1'b0, i_b}) begin
                    w_rem = w_rem - {1'b0, i_b};
                    w_sr  = {w_sr[Q_W-2:0], 1'b1};
                end else begin
                    w_sr  = {w_sr[Q_W-2:0], 1'b0};
                end
                // Remainder is below b < 2^MANT_W here, so bit MANT_W is always zero.
                w_acc = {{MANT_W{1'b0}}, w_rem[MANT_W-1:0], 1'b0};
            end
        end
    end

    assign o_acc = w_acc;
    assign o_sr  = w_sr;

endmodule

// File: rtl/fpu_mantissa_muldiv_iter.sv
// Iterative mantissa multiply / fixed-point divide with valid/ready handshakes, abort and tag pass-through.
module fpu_mantissa_muldiv_iter
    import fpu_muldiv_pkg::*;
#(
    parameter int MANT_W         = 64,
    parameter int GUARD_BITS     = 4,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_op,
    input  logic [MANT_W-1:0]   in_a,
    input  logic [MANT_W-1:0]   in_b,
    input  logic [TAG_W-1:0]    in_tag,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*MANT_W-1:0] out_result,
    output logic                out_sticky,
    output logic                out_div_by_zero,
    output logic                out_invalid,
    output logic [TAG_W-1:0]    out_tag,
    output logic                busy
);

    localparam int Q_W      = calc_q_w(MANT_W, GUARD_BITS);
    localparam int ITER_MUL = calc_iter(OP_MUL, MANT_W, GUARD_BITS, BITS_PER_CYCLE);
    localparam int ITER_DIV = calc_iter(OP_DIV, MANT_W, GUARD_BITS, BITS_PER_CYCLE);
    localparam int ITER_MAX = (ITER_DIV > ITER_MUL) ? ITER_DIV : ITER_MUL;
    localparam int CNT_W    = $clog2(ITER_MAX + 1);
    localparam int ACC_W    = 2*MANT_W + 1;

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (MANT_W % BITS_PER_CYCLE) != 0 || (Q_W % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("fpu_mantissa_muldiv_iter: illegal BITS_PER_CYCLE / width combination");
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_op;
    logic [MANT_W-1:0]  r_a;
    logic [MANT_W-1:0]  r_b;
    logic [TAG_W-1:0]   r_tag;
    logic [ACC_W-1:0]   r_acc;
    logic [Q_W-1:0]     r_sr;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [Q_W-1:0]     w_sr_nxt;
    logic               w_special;

    fpu_muldiv_step #(
        .MANT_W         (MANT_W),
        .Q_W            (Q_W),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_acc (r_acc),
        .i_sr  (r_sr),
        .o_acc (w_acc_nxt),
        .o_sr  (w_sr_nxt)
    );

    assign in_ready  = (r_state == IDLE) & reset;
    assign busy      = (r_state != IDLE);
    // A zero or unnormalised divisor would overflow the Q_W-bit quotient, so it never enters RUN.
    assign w_special = (in_op == OP_DIV) & ~in_b[MANT_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_op            <= OP_MUL;
            r_a             <= '0;
            r_b             <= '0;
            r_tag           <= '0;
            r_acc           <= '0;
            r_sr            <= '0;
            out_valid       <= 1'b0;
            out_result      <= '0;
            out_sticky      <= 1'b0;
            out_div_by_zero <= 1'b0;
            out_invalid     <= 1'b0;
            out_tag         <= '0;
        end else if (abort) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            out_valid       <= 1'b0;
            out_result      <= '0;
            out_sticky      <= 1'b0;
            out_div_by_zero <= 1'b0;
            out_invalid     <= 1'b0;
            out_tag         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op  <= in_op;
                        r_a   <= in_a;
                        r_b   <= in_b;
                        r_tag <= in_tag;
                        if (w_special) begin
                            r_state         <= DONE;
                            out_valid       <= 1'b1;
                            out_result      <= '0;
                            out_sticky      <= 1'b0;
                            out_div_by_zero <= (in_b == '0);
                            out_invalid     <= (in_b != '0);
                            out_tag         <= in_tag;
                        end else if (in_op == OP_DIV) begin
                            r_state <= RUN;
                            r_cnt   <= CNT_W'(ITER_DIV);
                            r_acc   <= ACC_W'(in_a);
                            r_sr    <= '0;
                        end else begin
                            r_state <= RUN;
                            r_cnt   <= CNT_W'(ITER_MUL);
                            r_acc   <= '0;
                            r_sr    <= Q_W'(in_b);
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_sr  <= w_sr_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state         <= DONE;
                        out_valid       <= 1'b1;
                        out_div_by_zero <= 1'b0;
                        out_invalid     <= 1'b0;
                        out_tag         <= r_tag;
                        if (r_op == OP_MUL) begin
                            out_result <= w_acc_nxt[2*MANT_W-1:0];
                            out_sticky <= 1'b0;
                        end else begin
                            out_result <= (2*MANT_W)'(w_sr_nxt);
                            out_sticky <= |w_acc_nxt[MANT_W:0];
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mantissa_muldiv_iter.sv
// Directed bench for the mantissa engine: radix-2 instance for most checks, radix-16 instance for latency/result.
module tb_fpu_mantissa_muldiv_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ab1 = 1'b0, ab4 = 1'b0;
    logic         iv1 = 1'b0, iv4 = 1'b0;
    logic         op1 = 1'b0, op4 = 1'b0;
    logic [63:0]  a1 = '0, b1 = '0, a4 = '0, b4 = '0;
    logic [3:0]   tag1 = '0, tag4 = '0;
    logic         or1 = 1'b0, or4 = 1'b0;
    logic         ir1, ir4, ov1, ov4, st1, st4, dz1, dz4, inv1, inv4, busy1, busy4;
    logic [127:0] res1, res4;
    logic [3:0]   ot1, ot4;

    int tests = 0;
    int fails = 0;
    int lat;
    int seen;

    always #5 clk = ~clk;

    fpu_mantissa_muldiv_iter #(.BITS_PER_CYCLE(1)) u1 (
        .clk(clk), .reset(rst_n), .in_valid(iv1), .in_ready(ir1), .in_op(op1), .in_a(a1),
        .in_b(b1), .in_tag(tag1), .abort(ab1), .out_valid(ov1), .out_ready(or1),
        .out_result(res1), .out_sticky(st1), .out_div_by_zero(dz1), .out_invalid(inv1),
        .out_tag(ot1), .busy(busy1));

    fpu_mantissa_muldiv_iter #(.BITS_PER_CYCLE(4)) u4 (
        .clk(clk), .reset(rst_n), .in_valid(iv4), .in_ready(ir4), .in_op(op4), .in_a(a4),
        .in_b(b4), .in_tag(tag4), .abort(ab4), .out_valid(ov4), .out_ready(or4),
        .out_result(res4), .out_sticky(st4), .out_div_by_zero(dz4), .out_invalid(inv4),
        .out_tag(ot4), .busy(busy4));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Edges after the accepting edge until out_valid is seen (0 = valid right after accept); -1 on timeout.
    task automatic waitv(input bit sel, output int n_out);
        n_out = -1;
        for (int n = 0; n < 200; n++) begin
            if (sel ? ov4 : ov1) begin
                n_out = n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input bit sel, input logic op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag, output int n_out);
        @(negedge clk);
        if (sel) begin iv4 = 1'b1; op4 = op; a4 = a; b4 = b; tag4 = tag; end
        else     begin iv1 = 1'b1; op1 = op; a1 = a; b1 = b; tag1 = tag; end
        @(posedge clk); #1;
        iv1 = 1'b0;
        iv4 = 1'b0;
        waitv(sel, n_out);
    endtask

    task automatic consume(input bit sel);
        @(negedge clk);
        if (sel) or4 = 1'b1; else or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        or4 = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst in_ready", {127'd0, ir1}, 128'd0);
        chk("rst out_valid", {127'd0, ov1}, 128'd0);
        chk("rst busy", {127'd0, busy1}, 128'd0);
        chk("rst result", res1, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("post-rst in_ready", {127'd0, ir1}, 128'd1);

        // Multiply 2^63 * 2^63
        issue(0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'hA, lat);
        chk("mul lat", lat, 128'd64);
        chk("mul result", res1, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
        chk("mul sticky", {127'd0, st1}, 128'd0);
        chk("mul tag", {124'd0, ot1}, 128'hA);
        chk("done in_ready", {127'd0, ir1}, 128'd0);
        consume(0);
        chk("consume valid", {127'd0, ov1}, 128'd0);

        // Divides with normalised divisor
        issue(0, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h5, lat);
        chk("div1 lat", lat, 128'd68);
        chk("div1 result", res1, 128'h8_0000_0000_0000_0000);
        chk("div1 sticky", {127'd0, st1}, 128'd0);
        consume(0);
        issue(0, 1'b1, 64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000, 4'h6, lat);
        chk("div2 lat", lat, 128'd68);
        chk("div2 result", res1, 128'h5_5555_5555_5555_5555);
        chk("div2 sticky", {127'd0, st1}, 128'd1);
        chk("div2 tag", {124'd0, ot1}, 128'h6);
        consume(0);

        // Specials: valid right after the accepting edge
        issue(0, 1'b1, 64'h8000_0000_0000_0000, 64'h0, 4'h1, lat);
        chk("dbz lat", lat, 128'd0);
        chk("dbz flag", {127'd0, dz1}, 128'd1);
        chk("dbz invalid", {127'd0, inv1}, 128'd0);
        chk("dbz result", res1, 128'd0);
        consume(0);
        issue(0, 1'b1, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'h2, lat);
        chk("inv lat", lat, 128'd0);
        chk("inv flag", {127'd0, inv1}, 128'd1);
        chk("inv dbz", {127'd0, dz1}, 128'd0);
        chk("inv result", res1, 128'd0);
        consume(0);

        // Back-pressure with a queued request
        issue(0, 1'b0, 64'd3, 64'd5, 4'h3, lat);
        chk("bp lat", lat, 128'd64);
        @(negedge clk);
        iv1 = 1'b1; op1 = 1'b0; a1 = 64'd7; b1 = 64'd9; tag1 = 4'h9;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ir1 !== 1'b0 || ov1 !== 1'b1 || res1 !== 128'd15 || ot1 !== 4'h3) seen++;
        end
        chk("bp stable cycles", seen, 128'd0);
        @(negedge clk) or1 = 1'b1;
        @(posedge clk); #1;
        or1 = 1'b0;
        chk("bp release valid", {127'd0, ov1}, 128'd0);
        chk("bp release in_ready", {127'd0, ir1}, 128'd1);
        @(posedge clk); #1;
        iv1 = 1'b0;
        chk("bp accept busy", {127'd0, busy1}, 128'd1);
        waitv(0, lat);
        chk("bp queued lat", lat, 128'd64);
        chk("bp queued result", res1, 128'd63);
        chk("bp queued tag", {124'd0, ot1}, 128'h9);
        consume(0);

        // Abort on the 20th RUN cycle
        @(negedge clk);
        iv1 = 1'b1; op1 = 1'b0; a1 = 64'hFFFF_FFFF_FFFF_FFFF; b1 = 64'hFFFF_FFFF_FFFF_FFFF; tag1 = 4'h7;
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (19) @(posedge clk);
        #1 ab1 = 1'b1;
        @(posedge clk); #1;
        ab1 = 1'b0;
        chk("abort busy", {127'd0, busy1}, 128'd0);
        chk("abort in_ready", {127'd0, ir1}, 128'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (ov1 !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        chk("abort no valid", seen, 128'd0);
        @(negedge clk);
        iv1 = 1'b1; ab1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; ab1 = 1'b0;
        chk("abort+valid busy", {127'd0, busy1}, 128'd0);
        issue(0, 1'b0, 64'hC90F_DAA2_2168_C235, 64'd2, 4'hC, lat);
        chk("post-abort lat", lat, 128'd64);
        chk("post-abort result", res1, 128'h1_921F_B544_42D1_846A);
        consume(0);

        // Async reset mid-divide clears outputs without a clock edge
        issue(0, 1'b0, 64'd6, 64'd7, 4'hE, lat);
        consume(0);
        @(negedge clk);
        iv1 = 1'b1; op1 = 1'b1; a1 = 64'h8000_0000_0000_0000; b1 = 64'h8000_0000_0000_0000; tag1 = 4'hB;
        @(posedge clk); #1;
        iv1 = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst busy", {127'd0, busy1}, 128'd0);
        chk("arst result", res1, 128'd0);
        chk("arst tag", {124'd0, ot1}, 128'd0);
        chk("arst in_ready", {127'd0, ir1}, 128'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (ov1 !== 1'b0) seen++;
        end
        chk("arst no result", seen, 128'd0);

        // Radix-16 instance
        issue(1, 1'b0, 64'hC90F_DAA2_2168_C235, 64'h8000_0000_0000_0000, 4'h4, lat);
        chk("r16 mul lat", lat, 128'd16);
        chk("r16 mul result", res4, 128'h6487_ED51_10B4_611A_8000_0000_0000_0000);
        chk("r16 mul tag", {124'd0, ot4}, 128'h4);
        consume(1);
        issue(1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h8, lat);
        chk("r16 div lat", lat, 128'd17);
        chk("r16 div result", res4, 128'h8_0000_0000_0000_0000);
        chk("r16 div sticky", {127'd0, st4}, 128'd0);
        consume(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
